// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit 3-sample majority voting, optional parity,
// one or two stop bits, and a small FIFO of {data, perr, ferr} entries
// drained through a valid/ready pop port.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;
  localparam int BW       = $clog2(DATA_BITS + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic          rx_m, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic          s0, s1, vote, mid, bit_end;
  logic [DATA_BITS-1:0] shreg;
  logic          perr_r, ferr_r, brk_wait;
  logic          push;
  entry_t        push_e;

  // Two-flop synchroniser; resets high so the idle line is not seen as a start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running sample-tick divider, never re-phased by the line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DW'(TICK_DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // s0/s1 hold samples M-1 and M; rx_s is sample M+1 at the decision tick
  assign vote    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign mid     = (scnt == SW'(M + 1));
  assign bit_end = (scnt == SW'(OVERSAMPLE - 1));

  // Frame FSM: start qualification, data shift, parity, stop, push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      scnt     <= '0;
      bcnt     <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      shreg    <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      brk_wait <= 1'b0;
      push     <= 1'b0;
      push_e   <= '0;
    end else begin
      push <= 1'b0;
      if (tick) begin
        if (state != S_IDLE) begin
          scnt <= bit_end ? '0 : scnt + 1'b1;
          if (scnt == SW'(M - 1)) s0 <= rx_s;
          if (scnt == SW'(M))     s1 <= rx_s;
        end
        case (state)
          S_IDLE: begin
            if (brk_wait) begin
              if (rx_s) brk_wait <= 1'b0;
            end else if (!rx_s) begin
              state  <= S_START;
              scnt   <= '0;
              bcnt   <= '0;
              perr_r <= 1'b0;
              ferr_r <= 1'b0;
            end
          end
          S_START: begin
            if (mid && vote) state <= S_IDLE;
            else if (bit_end) state <= S_DATA;
          end
          S_DATA: begin
            if (mid) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_end) begin
              if (bcnt == BW'(DATA_BITS - 1)) begin
                bcnt  <= '0;
                state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
          S_PAR: begin
            if (mid) perr_r <= (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
            if (bit_end) state <= S_STOP;
          end
          S_STOP: begin
            if (mid) begin
              if (bcnt == BW'(STOP_BITS - 1)) begin
                push     <= 1'b1;
                push_e   <= {shreg, perr_r, ferr_r | ~vote};
                brk_wait <= (shreg == '0) && !vote;
                state    <= S_IDLE;
              end else begin
                ferr_r <= ferr_r | ~vote;
              end
            end
            if (bit_end) bcnt <= bcnt + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO control
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] cnt_n;
  logic          do_pop, do_push;
  entry_t        head_n;

  assign do_pop  = rx_valid && rx_ready;
  assign do_push = push && ((fifo_count != CW'(FIFO_DEPTH)) || do_pop);
  assign rptr_n  = rptr + AW'(do_pop);
  assign cnt_n   = fifo_count + CW'(do_push) - CW'(do_pop);

  // Next head: bypass the incoming entry when it lands on an empty slot
  always_comb begin
    head_n = mem[rptr_n];
    if (do_push && (rptr_n == wptr)) head_n = push_e;
    if (cnt_n == '0) head_n = '0;
  end

  // Storage array, write-only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_e;
  end

  // Pointers, occupancy, registered head and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      rptr       <= rptr_n;
      fifo_count <= cnt_n;
      rx_valid   <= (cnt_n != '0);
      rx_data    <= head_n.data;
      rx_perr    <= head_n.perr;
      rx_ferr    <= head_n.ferr;
      if (push && !do_push) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1, 8E1, 7O2) share a clock
// and reset; frames are built bit by bit and a queue model predicts entries.
module tb_uart_rx_fifo;

  localparam int BIT = 160;

  logic clk = 1'b0;
  logic reset_n;
  logic rx [3];
  logic rdy [3];
  logic clr [3];

  logic [7:0] d_a, d_b;
  logic [6:0] d_c;
  logic       pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;
  logic       v_a, v_b, v_c, ov_a, ov_b, ov_c;
  logic [2:0] c_a, c_b, c_c;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { int d; int pe; int fe; } ent_t;
  ent_t mq [3][$];
  int   mov [3];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset_n(reset_n), .rx(rx[0]), .rx_data(d_a), .rx_perr(pe_a),
    .rx_ferr(fe_a), .rx_valid(v_a), .rx_ready(rdy[0]), .fifo_count(c_a),
    .overrun(ov_a), .overrun_clr(clr[0]));

  uart_rx_fifo #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset_n(reset_n), .rx(rx[1]), .rx_data(d_b), .rx_perr(pe_b),
    .rx_ferr(fe_b), .rx_valid(v_b), .rx_ready(rdy[1]), .fifo_count(c_b),
    .overrun(ov_b), .overrun_clr(clr[1]));

  uart_rx_fifo #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .reset_n(reset_n), .rx(rx[2]), .rx_data(d_c), .rx_perr(pe_c),
    .rx_ferr(fe_c), .rx_valid(v_c), .rx_ready(rdy[2]), .fifo_count(c_c),
    .overrun(ov_c), .overrun_clr(clr[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input int u, output logic [31:0] d, output logic [31:0] pe,
                      output logic [31:0] fe, output logic [31:0] v,
                      output logic [31:0] c, output logic [31:0] o);
    case (u)
      0: begin d = 32'(d_a); pe = 32'(pe_a); fe = 32'(fe_a); v = 32'(v_a); c = 32'(c_a); o = 32'(ov_a); end
      1: begin d = 32'(d_b); pe = 32'(pe_b); fe = 32'(fe_b); v = 32'(v_b); c = 32'(c_b); o = 32'(ov_b); end
      default: begin d = 32'(d_c); pe = 32'(pe_c); fe = 32'(fe_c); v = 32'(v_c); c = 32'(c_c); o = 32'(ov_c); end
    endcase
  endtask

  // Compare occupancy, valid, head entry and overrun against the model
  task automatic check_state(input int u, input string tag);
    logic [31:0] d, pe, fe, v, c, o;
    @(negedge clk);
    look(u, d, pe, fe, v, c, o);
    chk({tag, ".count"}, c, mq[u].size());
    chk({tag, ".valid"}, v, 32'(mq[u].size() != 0));
    if (mq[u].size() != 0) begin
      chk({tag, ".data"}, d, mq[u][0].d);
      chk({tag, ".perr"}, pe, mq[u][0].pe);
      chk({tag, ".ferr"}, fe, mq[u][0].fe);
    end
    chk({tag, ".overrun"}, o, mov[u]);
  endtask

  task automatic check_zero(input int u, input string tag);
    logic [31:0] d, pe, fe, v, c, o;
    look(u, d, pe, fe, v, c, o);
    chk({tag, ".data0"}, d, 0);
    chk({tag, ".perr0"}, pe, 0);
    chk({tag, ".ferr0"}, fe, 0);
    chk({tag, ".valid0"}, v, 0);
    chk({tag, ".count0"}, c, 0);
    chk({tag, ".ovr0"}, o, 0);
  endtask

  task automatic model_push(input int u, input int d, input int pe, input int fe);
    ent_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    if (mq[u].size() < 4) mq[u].push_back(e);
    else mov[u] = 1;
  endtask

  task automatic drive(input int u, input logic v, input bit glitch);
    @(negedge clk);
    rx[u] = v;
    if (glitch) begin
      repeat (75) @(negedge clk);
      rx[u] = ~v;
      repeat (10) @(negedge clk);
      rx[u] = v;
      repeat (74) @(negedge clk);
    end else begin
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int u, input int nbits);
    rx[u] = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  // One frame: start, nd data bits LSB first, optional parity pb, ns stop bits
  // at level sv; gb selects a data bit that gets a one-tick mid-bit glitch.
  task automatic send(input int u, input int nd, input int d, input int pm,
                      input int pb, input int ns, input int sv, input int gb);
    int dm, ones;
    dm = d & ((1 << nd) - 1);
    drive(u, 1'b0, 1'b0);
    for (int i = 0; i < nd; i++) drive(u, 1'((dm >> i) & 1), i == gb);
    if (pm != 0) drive(u, 1'(pb), 1'b0);
    for (int s = 0; s < ns; s++) drive(u, 1'(sv), 1'b0);
    rx[u] = 1'b1;
    ones = $countones(dm) + ((pm != 0) ? pb : 0);
    model_push(u, dm, (pm == 1) ? int'(ones % 2 == 0) : (pm == 2) ? int'(ones % 2 == 1) : 0,
               int'(sv == 0));
  endtask

  task automatic pop(input int u);
    @(negedge clk);
    rdy[u] = 1'b1;
    @(negedge clk);
    rdy[u] = 1'b0;
    if (mq[u].size() != 0) void'(mq[u].pop_front());
  endtask

  task automatic drain(input int u, input string tag);
    while (mq[u].size() != 0) begin
      pop(u);
      check_state(u, tag);
    end
  endtask

  initial begin
    int d, pb;
    reset_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      rx[u] = 1'b1; rdy[u] = 1'b0; clr[u] = 1'b0; mov[u] = 0;
    end
    repeat (5) @(negedge clk);
    for (int u = 0; u < 3; u++) check_zero(u, "reset");
    reset_n = 1'b1;
    for (int u = 0; u < 3; u++) idle(u, 0);
    repeat (2 * BIT) @(negedge clk);

    // Two back-to-back 8N1 characters
    send(0, 8, 'hA5, 0, 0, 1, 1, -1);
    send(0, 8, 'h3C, 0, 0, 1, 1, -1);
    check_state(0, "b2b");
    drain(0, "b2b_pop");

    // Even parity, correct then wrong parity bit
    send(1, 8, 'h07, 2, 1, 1, 1, -1);
    send(1, 8, 'h07, 2, 0, 1, 1, -1);
    check_state(1, "even");
    drain(1, "even_pop");

    // Framing error, 10-bit break, then a long break that must yield one entry
    send(0, 8, 'h55, 0, 0, 1, 0, -1);
    idle(0, 2);
    rx[0] = 1'b0;
    repeat (10 * BIT) @(negedge clk);
    model_push(0, 0, 0, 1);
    idle(0, 3);
    check_state(0, "break10");
    rx[0] = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    model_push(0, 0, 0, 1);
    idle(0, 3);
    check_state(0, "break30");
    drain(0, "brk_pop");
    d = $urandom_range(1, 255);
    send(0, 8, d, 0, 0, 1, 1, -1);
    check_state(0, "after_brk");
    drain(0, "after_brk_pop");

    // Short idle-line glitch, then a mid-bit glitch inside 0xFF
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    idle(0, 2);
    check_state(0, "idle_glitch");
    send(0, 8, 'hFF, 0, 0, 1, 1, 3);
    check_state(0, "vote");
    drain(0, "vote_pop");

    // Overrun with the consumer stalled
    for (int k = 1; k <= 5; k++) send(0, 8, k, 0, 0, 1, 1, -1);
    check_state(0, "ovr");
    @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    mov[0] = 0;
    check_state(0, "ovr_clr");
    drain(0, "ovr_pop");

    // Random 8N1 traffic with random gaps
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        send(0, 8, $urandom_range(0, 255), 0, 0, 1, 1, -1);
        idle(0, $urandom_range(0, 1));
      end
      check_state(0, "rand_a");
      drain(0, "rand_a_pop");
    end

    // Random even-parity traffic with random parity bits
    for (int k = 0; k < 3; k++) begin
      send(1, 8, $urandom_range(0, 255), 2, $urandom_range(0, 1), 1, 1, -1);
    end
    check_state(1, "rand_b");
    drain(1, "rand_b_pop");

    // 7O2: 0x41 needs parity bit 1, then reset in the middle of the next frame
    send(2, 7, 'h41, 1, 1, 2, 1, -1);
    check_state(2, "7o2");
    d = $urandom_range(0, 127);
    drive(2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(2, 1'((d >> i) & 1), 1'b0);
    rx[2] = 1'((d >> 3) & 1);
    repeat (80) @(negedge clk);
    reset_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      mq[u].delete();
      mov[u] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero(2, "mid_rst");
    check_zero(0, "mid_rst_a");
    rx[2] = 1'b1;
    reset_n = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_zero(2, "post_rst");
    check_state(2, "post_rst_state");

    pb = n_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, pb);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver. It supports configurable data width, parity, stop-bit count and oversampling, and uses 3-sample majority voting at mid-bit. Received characters and their per-character error flags go into an on-chip FIFO with a valid/ready pop interface. It sits between the board RX pin and the command/time-setting parser of the calendar, replacing the single-byte receiver.

Parameters:
CLOCK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in baud
OVERSAMPLE, 16, samples per bit; even, 8 to 32
DATA_BITS, 8, data bits per character; 5 to 9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, number of entries; power of two, at least 2

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
rx  in  1  serial input, asynchronous to clk, idles high
rx_data  out  DATA_BITS  character at the FIFO head
rx_perr  out  1  parity error flag of the head entry; always 0 when PARITY=0
rx_ferr  out  1  framing error flag of the head entry
rx_valid  out  1  FIFO non-empty; head outputs are valid
rx_ready  in  1  consumer pop; a pop happens on a cycle with rx_valid && rx_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overrun  out  1  sticky: a character was dropped because the FIFO was full
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (reset_n low, asynchronous):
  - all outputs 0, FIFO empty, state IDLE;
  - synchroniser flops reset to 1, so no false start is seen after reset;
  - reset mid-frame discards the partial character.
- Input path: rx passes through a 2-flop synchroniser before any use; rx_s denotes the synchronised value.
- Sample tick: one-cycle pulse every TICK_DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) cycles, with TICK_DIV >= 1.
  - The divider free-runs. It is never restarted on a start edge.
  - Start alignment uncertainty is therefore at most one tick.
- Sample counter: counts 0..OVERSAMPLE-1 ticks within a bit.
- Bit value: majority of rx_s taken at sample counts M-1, M and M+1, where M = OVERSAMPLE/2. It is decided at count M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - On a tick where rx_s = 0: go to START with sample counter 0.
  - START:
    - At the mid-bit decision: if the vote is 1 (glitch), return to IDLE with nothing written and no error.
    - If the vote is 0: go to DATA when the bit ends.
  - DATA:
    - DATA_BITS bits, LSB first, shifted into the data register.
    - After the last bit: go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY:
    - Odd: perr = (XOR of data XOR parity bit) == 0.
    - Even: perr = (XOR of data XOR parity bit) == 1.
  - STOP:
    - ferr = 1 if any stop bit votes 0.
    - With STOP_BITS = 2, both stop bits are sampled.
    - At the mid-bit decision of the last stop bit, push {data, perr, ferr} and go straight to IDLE. The half stop bit is not waited out, so back-to-back frames are accepted.
- Break condition (all zeros including stop): stored as data 0 with ferr = 1. The FSM then stays in IDLE until rx_s returns to 1 before it arms a new start.
- FIFO:
  - Registered storage; circular read and write pointers that wrap modulo FIFO_DEPTH.
  - The head outputs are registered from storage. rx_valid rises the cycle after a push into an empty FIFO, so push-to-visible latency is 1 cycle.
  - Pop: the head advances the cycle after the handshake. With rx_valid = 0, rx_ready is ignored.
  - Push while full without a simultaneous pop: the character is dropped and overrun is set on the next cycle.
  - Push while full with a simultaneous pop: both happen and occupancy is unchanged.
  - Push and pop together at any other occupancy: occupancy is unchanged.
- overrun: stays set until overrun_clr is sampled high. If overrun_clr and a new overrun occur in the same cycle, set wins.
- fifo_count stays within 0..FIFO_DEPTH.

Test Plan:
Bench parameters for all scenarios: CLOCK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving 160 clk per bit.
1. DATA_BITS=8, PARITY=0, STOP_BITS=1. Send 0xA5, then 0x3C back-to-back. Required: rx_valid rises; head 0xA5 with perr=0 and ferr=0; after a pop the head is 0x3C; after a second pop fifo_count=0.
2. PARITY=2 (even). Send 0x07 with parity bit 1 (correct), then 0x07 with parity bit 0. Required: entries {0x07, perr=0}, then {0x07, perr=1}.
3. Stop bit driven 0 on 0x55; separately, a 10-bit-time break. Required: {0x55, ferr=1}, then {0x00, ferr=1}, and no further entries until rx returns high and a new start bit arrives.
4. 3-clk low glitch on an idle line; separately, a single-tick glitch in mid-bit of a data bit of 0xFF. Required: no entry for the first; the second is received as 0xFF because the majority vote holds.
5. FIFO_DEPTH=4, rx_ready=0, send 5 characters 0x01..0x05. Required: fifo_count=4, overrun=1, head 0x01, 0x05 lost. Pulse overrun_clr; required: overrun=0.
6. DATA_BITS=7, PARITY=1 (odd), STOP_BITS=2. Send 0x41. Pull reset_n low mid-data of the next frame. Required: 0x41 stored with no errors; after reset all outputs are 0 and fifo_count=0.
